// File: rtl/calc_pkg.sv
// Shared definitions for the 4-bit calculator command path:
// operand width, operation codes and the sequencer state type.
package calc_pkg;

  localparam int CALC_W = 4;

  localparam logic [1:0] MODE_SUB = 2'b00;
  localparam logic [1:0] MODE_ADD = 2'b01;
  localparam logic [1:0] MODE_MUL = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_M,
    EXEC,
    RESP
  } seq_state_t;

endpackage

// File: rtl/calc_ovf_check.sv
// Flags when the exact unsigned result of a calculator operation
// does not fit in CALC_W bits; purely combinational.
module calc_ovf_check
  import calc_pkg::*;
(
  input  logic [CALC_W-1:0] a,
  input  logic [CALC_W-1:0] b,
  input  logic [1:0]        mode,
  output logic              ovf
);

  logic [CALC_W:0]     w_sum;
  logic [2*CALC_W-1:0] w_prod;

  // Widened domains so the true result is never truncated before comparing.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_prod = {{CALC_W{1'b0}}, a} * {{CALC_W{1'b0}}, b};

  always_comb begin
    ovf = 1'b0;
    case (mode)
      MODE_SUB: ovf = (a < b);
      MODE_ADD: ovf = w_sum[CALC_W];
      MODE_MUL: ovf = |w_prod[2*CALC_W-1:CALC_W];
      MODE_CLR: ovf = 1'b0;
      default:  ovf = 1'b0;
    endcase
  end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Collects A, B and mode nibbles, holds them at the calculator, waits
// CALC_LAT+1 cycles and offers the captured result on a valid/ready port.
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int CALC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CALC_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [CALC_W-1:0] calc_a,
  output logic [CALC_W-1:0] calc_b,
  output logic [1:0]        calc_mode,
  input  logic [CALC_W-1:0] calc_c,
  output logic [CALC_W-1:0] res,
  output logic              res_ovf,
  output logic              res_err,
  output logic              res_valid,
  input  logic              res_ready
);

  localparam logic [3:0] LAT_CNT = 4'(CALC_LAT);

  seq_state_t        r_state;
  seq_state_t        w_state_next;
  logic              w_get_ready;
  logic              w_fire;
  logic              w_capture;
  logic              w_ovf;
  logic [3:0]        r_cnt;
  logic              r_err;
  logic [CALC_W-1:0] r_calc_a;
  logic [CALC_W-1:0] r_calc_b;
  logic [1:0]        r_calc_mode;
  logic [CALC_W-1:0] r_res;
  logic              r_res_ovf;
  logic              r_res_err;
  logic              r_res_valid;

  calc_ovf_check u_ovf (
    .a    (r_calc_a),
    .b    (r_calc_b),
    .mode (r_calc_mode),
    .ovf  (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= GET_A;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_get_ready  = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      GET_A: begin
        w_get_ready = 1'b1;
        if (din_valid) w_state_next = GET_B;
      end
      GET_B: begin
        w_get_ready = 1'b1;
        if (din_valid) w_state_next = GET_M;
      end
      GET_M: begin
        w_get_ready = 1'b1;
        if (din_valid) w_state_next = EXEC;
      end
      EXEC: begin
        if (r_cnt == LAT_CNT) begin
          w_capture    = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (r_res_valid && res_ready) w_state_next = GET_A;
      end
      default: w_state_next = GET_A;
    endcase
  end

  // Ready is masked by reset so nothing is advertised during a reset cycle.
  assign din_ready = w_get_ready & rst;
  assign w_fire    = din_valid & din_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_calc_a    <= '0;
      r_calc_b    <= '0;
      r_calc_mode <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_res       <= '0;
      r_res_ovf   <= 1'b0;
      r_res_err   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      if (r_state == GET_A && w_fire) r_calc_a <= din;
      if (r_state == GET_B && w_fire) r_calc_b <= din;
      if (r_state == GET_M && w_fire) begin
        r_calc_mode <= din[1:0];
        r_err       <= |din[3:2];
        r_cnt       <= '0;
      end
      if (r_state == EXEC && !w_capture) r_cnt <= r_cnt + 4'd1;
      if (w_capture) begin
        r_res       <= calc_c;
        r_res_ovf   <= w_ovf;
        r_res_err   <= r_err;
        r_res_valid <= 1'b1;
      end
      if (r_state == RESP && r_res_valid && res_ready) r_res_valid <= 1'b0;
    end
  end

  assign calc_a    = r_calc_a;
  assign calc_b    = r_calc_b;
  assign calc_mode = r_calc_mode;
  assign res       = r_res;
  assign res_ovf   = r_res_ovf;
  assign res_err   = r_res_err;
  assign res_valid = r_res_valid;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Self-checking bench: directed commands plus random back-to-back traffic,
// with a registered calculator model and an arithmetic reference.
module tb_calc_cmd_sequencer;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] din = 4'd0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [3:0] calc_a;
  logic [3:0] calc_b;
  logic [1:0] calc_mode;
  logic [3:0] calc_c;
  logic [3:0] res;
  logic       res_ovf;
  logic       res_err;
  logic       res_valid;
  logic       res_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int ncmd = 0;

  logic [3:0] pipe [LAT];

  calc_cmd_sequencer #(.CALC_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .calc_a    (calc_a),
    .calc_b    (calc_b),
    .calc_mode (calc_mode),
    .calc_c    (calc_c),
    .res       (res),
    .res_ovf   (res_ovf),
    .res_err   (res_err),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] calc_fn(input int a, input int b, input int m);
    int r;
    case (m)
      0:       r = a - b;
      1:       r = a + b;
      2:       r = a * b;
      default: r = 0;
    endcase
    return 4'(r & 15);
  endfunction

  function automatic int ref_ovf(input int a, input int b, input int m);
    case (m)
      0:       return (a < b) ? 1 : 0;
      1:       return (a + b > 15) ? 1 : 0;
      2:       return (a * b > 15) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Calculator with LAT register stages from operands to result.
  always @(posedge clk) begin
    pipe[0] <= calc_fn(int'(calc_a), int'(calc_b), int'(calc_mode));
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign calc_c = pipe[LAT-1];

  always @(posedge clk) begin
    cyc++;
    if (rst && res_valid && res_ready) hs_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] v, input int gap, output int at_cyc);
    int n;
    din_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      check("hold_din_ready", int'(din_ready), 1);
    end
    din = v;
    din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("din_ready_wait", int'(din_ready), 1);
    @(posedge clk); #1;
    at_cyc = cyc;
    din_valid = 1'b0;
    din = 4'($urandom);
  endtask

  task automatic run_cmd(input int a, input int b, input int mnib, input int gap, input int stall);
    int t, e0, n, m, er, eo;
    m  = mnib & 3;
    er = ((mnib >> 2) != 0) ? 1 : 0;
    eo = ref_ovf(a, b, m);
    send(4'(a), gap, t);
    check("calc_a", int'(calc_a), a);
    send(4'(b), gap, t);
    check("calc_b", int'(calc_b), b);
    send(4'(mnib), gap, e0);
    check("calc_mode", int'(calc_mode), m);
    check("exec_din_ready", int'(din_ready), 0);
    n = 0;
    while (!res_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", cyc - e0, LAT + 1);
    check("res", int'(res), int'(calc_fn(a, b, m)));
    check("res_ovf", int'(res_ovf), eo);
    check("res_err", int'(res_err), er);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", int'(res_valid), 1);
      check("stall_res", int'(res), int'(calc_fn(a, b, m)));
      check("stall_ovf", int'(res_ovf), eo);
      check("stall_din_ready", int'(din_ready), 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("post_hs_valid", int'(res_valid), 0);
    check("post_hs_din_ready", int'(din_ready), 1);
    check("post_hs_calc_a", int'(calc_a), a);
    $display("cmd a=%0d b=%0d mode=%b -> res=%0d ovf=%0d err=%0d", a, b, 4'(mnib), res, res_ovf, res_err);
    ncmd++;
  endtask

  initial begin
    int t;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_din_ready", int'(din_ready), 0);
    check("rst_calc_a", int'(calc_a), 0);
    check("rst_calc_b", int'(calc_b), 0);
    check("rst_calc_mode", int'(calc_mode), 0);
    check("rst_res", int'(res), 0);
    check("rst_res_valid", int'(res_valid), 0);
    rst = 1'b1;
    #1;
    check("rst_release_ready", int'(din_ready), 1);

    run_cmd(9, 3, 0, 0, 0);
    run_cmd(9, 8, 1, 0, 0);
    run_cmd(3, 5, 2, 0, 0);
    run_cmd(4, 4, 2, 0, 0);
    run_cmd(2, 7, 0, 0, 0);
    run_cmd(6, 9, 4'b0111, 0, 0);
    run_cmd(12, 5, 1, 4, 5);

    // Reset in the middle of EXEC discards the pending command.
    send(4'd5, 0, t);
    send(4'd5, 0, t);
    send(4'd1, 0, t);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_din_ready", int'(din_ready), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_state_ready", int'(din_ready), 1);
    check("midrst_calc_a", int'(calc_a), 0);
    check("midrst_calc_b", int'(calc_b), 0);
    check("midrst_calc_mode", int'(calc_mode), 0);
    check("midrst_res", int'(res), 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("midrst_no_valid", int'(res_valid), 0);
    end
    run_cmd(1, 1, 1, 0, 0);

    for (int i = 0; i < 20; i++) begin
      run_cmd(int'($urandom_range(15)), int'($urandom_range(15)),
              int'($urandom_range(15)), 0, 0);
    end

    check("handshake_count", hs_cnt, ncmd);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_cmd_sequencer.md
# calc_cmd_sequencer

Upstream command sequencer for the 4-bit calculator stage. It collects operand A, operand B and the 2-bit operation code as three successive nibbles over a valid/ready input, and drives them stable to the calculator. It waits a fixed number of cycles for the registered result, then captures the result together with an overflow flag and a command-error flag. The captured result is offered on a valid/ready output until the consumer accepts it.

## Interface
- `CALC_LAT`, default 1: clock edges between stable operands at the calculator inputs and a valid calculator result; range 1..15.
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `din`  in  4: input nibble (A, then B, then mode in `din[1:0]`).
- `din_valid`  in  1: `din` is valid.
- `din_ready`  out  1: the sequencer accepts `din` this cycle.
- `calc_a`  out  4: operand A to the calculator (registered).
- `calc_b`  out  4: operand B to the calculator (registered).
- `calc_mode`  out  2: operation code: 00 = sub, 01 = add, 10 = mul, 11 = clear.
- `calc_c`  in  4: result returned by the calculator.
- `res`  out  4: captured result.
- `res_ovf`  out  1: the true result was not representable in 4 bits (unsigned).
- `res_err`  out  1: `din[3:2]` was nonzero in the mode nibble.
- `res_valid`  out  1: `res`, `res_ovf` and `res_err` are valid.
- `res_ready`  in  1: the consumer accepts the result.

## Operation
- States: GET_A, GET_B, GET_M, EXEC, RESP. The reset state is GET_A.
- Reset values: `calc_a`, `calc_b`, `calc_mode`, `res`, `res_ovf`, `res_err`, `res_valid` and the wait counter are all 0. `din_ready` is 0 in any cycle with `rst` = 0.
- `din_ready` is 1 exactly in GET_A, GET_B and GET_M. A transfer happens on `din_valid && din_ready`.
- GET_A: on transfer, `calc_a <= din`, go to GET_B.
- GET_B: on transfer, `calc_b <= din`, go to GET_M.
- GET_M: on transfer, `calc_mode <= din[1:0]`, latch `err <= |din[3:2]`, clear the counter, go to EXEC.
- Without a transfer, each of the three GET states holds.
- EXEC: `calc_*` are held constant.
  - If `cnt == CALC_LAT`: `res <= calc_c`, `res_ovf <=` computed flag, `res_err <= err`, `res_valid <= 1`, go to RESP.
  - Otherwise `cnt <= cnt + 1`.
- RESP: hold all outputs. On `res_valid && res_ready`: `res_valid <= 0`, go to GET_A. The `calc_*` outputs keep their last values.
- Overflow rule, evaluated on the held operands in a 5-bit/8-bit unsigned domain:
  - sub: `a < b`
  - add: `a + b > 15`
  - mul: `a * b > 15`
  - clear: 0
- `res` is always the captured `calc_c`. The sequencer never recomputes it.
- Reset at any point, including mid-EXEC and in RESP, returns to GET_A with reset values at the next edge. A pending result is discarded.
- `din` values outside the GET states are ignored, because `din_ready` is 0 there.

## Timing
- One nibble is accepted per cycle at most. The minimum issue time is 3 cycles.
- The mode transfer happens at edge E0. `res_valid` rises after edge E0 + `CALC_LAT` + 1.
- EXEC lasts `CALC_LAT` + 1 cycles. This gives one cycle of margin after the calculator's own edge.
- On the result handshake at edge Eh, `din_ready` is 1 in the cycle after Eh.
- Best-case throughput: 3 + (`CALC_LAT` + 1) + 1 cycles per command.
- `res`, `res_ovf` and `res_err` are stable while `res_valid` = 1 and `res_ready` = 0.

## Structure
- Shared package `calc_pkg`:
  - mode codes `MODE_SUB` = 2'b00, `MODE_ADD` = 2'b01, `MODE_MUL` = 2'b10, `MODE_CLR` = 2'b11
  - state enum `seq_state_t`
  - `CALC_W` = 4
- Sub-module `calc_ovf_check`: combinational; inputs a, b, mode; output ovf. It can be reused by the bench scoreboard.
- All other logic lives in `calc_cmd_sequencer`: FSM, counter and output registers.

## Test plan
- A=9, B=3, mode=00, `res_ready` = 1: `res` = 6, `res_ovf` = 0, `res_err` = 0. `res_valid` rises `CALC_LAT` + 1 edges after the mode transfer.
- Overflow cases:
  - A=9, B=8, mode=01 gives `res` = 1, `res_ovf` = 1.
  - A=3, B=5, mode=10 gives `res` = 15, `res_ovf` = 0.
  - A=4, B=4, mode=10 gives `res` = 0, `res_ovf` = 1.
  - A=2, B=7, mode=00 gives `res` = 11, `res_ovf` = 1.
- Mode nibble `din` = 4'b0111: `calc_mode` = 11, `res` = 0, `res_ovf` = 0, `res_err` = 1.
- Hold `din_valid` low for 4 cycles between nibbles: the state holds and results are unchanged. `res_ready` low for 5 cycles in RESP: outputs stay stable, `din_ready` stays 0, and the handshake on cycle 6 returns to GET_A.
- `rst` = 0 for one cycle during EXEC (after A=5, B=5, mode=01): next cycle is GET_A, all outputs are 0, and no `res_valid` appears. A following command A=1, B=1, mode=01 gives `res` = 2.
- Run `CALC_LAT` = 3 with back-to-back commands: latency is 4 edges and there is no lost or duplicated result across 20 random commands, checked against `calc_ovf_check` and a 4-bit model.
